// File: rtl/regslv_arb_pkg.sv
// Shared types for the register-slave request arbiter: FSM states,
// response error encoding and the command legality rule.
package regslv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  // A command is legal only when it is exactly a write or exactly a read.
  function automatic logic cmd_legal(input logic wr, input logic rd);
    return wr ^ rd;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester found after ptr
// (wrapping) wins; returns both a one-hot and an encoded grant.
module rr_arbiter #(
  parameter int REQ_NUM = 2,
  parameter int IDX_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [REQ_NUM-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int n);
    return IDX_W'(n % REQ_NUM);
  endfunction

  logic [IDX_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = '0;
    for (int off = REQ_NUM; off >= 1; off--) begin
      cand = wrap_idx(int'(ptr) + off);
      if (req[cand]) begin
        grant_oh       = '0;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/regslv_req_arb.sv
// Round-robin arbiter sharing one register-slave port among REQ_NUM masters,
// one transaction in flight, with timeout and local rejection of bad commands.
module regslv_req_arb
  import regslv_arb_pkg::*;
#(
  parameter int REQ_NUM    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            m_req_vld,
  input  logic [REQ_NUM-1:0]            m_wr_en,
  input  logic [REQ_NUM-1:0]            m_rd_en,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] m_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] m_wr_data,
  output logic [REQ_NUM-1:0]            m_ack_vld,
  output logic [REQ_NUM-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]         m_rd_data,
  output logic                          req_vld,
  output logic                          wr_en,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          ack_vld,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);

  // Handshake: a master holds m_req_vld and a stable command until it samples
  // its one-cycle m_ack_vld, then drops the request on that same edge. Toward
  // the slave, req_vld is a one-cycle pulse and ack_vld counts only in WAIT.

  localparam int IDX_W = $clog2(REQ_NUM);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     grant_q, ptr_q, pick_idx;
  logic [REQ_NUM-1:0]   pick_oh;
  logic [CNT_W-1:0]     cnt_q;
  logic                 err_q;
  logic                 pick_wr, pick_rd, pick_legal;
  logic                 grant_load, issue, wait_ack, wait_to;

  rr_arbiter #(.REQ_NUM(REQ_NUM), .IDX_W(IDX_W)) u_rr (
    .req       (m_req_vld),
    .ptr       (ptr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx)
  );

  assign pick_wr    = |(m_wr_en & pick_oh);
  assign pick_rd    = |(m_rd_en & pick_oh);
  assign pick_legal = cmd_legal(pick_wr, pick_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    issue      = 1'b0;
    wait_ack   = 1'b0;
    wait_to    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|m_req_vld) begin
          grant_load = 1'b1;
          if (pick_legal) begin
            issue   = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (ack_vld) begin
          wait_ack = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          wait_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      ptr_q     <= IDX_W'(REQ_NUM - 1);
      cnt_q     <= '0;
      err_q     <= ERR_NONE;
      m_rd_data <= '0;
      req_vld   <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
    end else begin
      req_vld <= issue;
      if (grant_load) begin
        grant_q <= pick_idx;
        ptr_q   <= pick_idx;
        wr_en   <= pick_wr;
        rd_en   <= pick_rd;
        addr    <= m_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data <= m_wr_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (issue) cnt_q <= '0;
      else if (state_q == WAIT && !wait_ack && !wait_to) cnt_q <= cnt_q + 1'b1;
      // Rejected or timed-out transactions report zero read data.
      if ((grant_load && !pick_legal) || wait_to) begin
        err_q     <= ERR_FAIL;
        m_rd_data <= '0;
      end else if (wait_ack) begin
        err_q     <= ERR_NONE;
        m_rd_data <= rd_data;
      end
    end
  end

  always_comb begin
    m_ack_vld = '0;
    m_err     = '0;
    if (state_q == RESP) begin
      m_ack_vld[grant_q] = 1'b1;
      m_err[grant_q]     = err_q;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_regslv_req_arb.sv
// Directed bench for regslv_req_arb: two masters, TIMEOUT=8, slave driven
// cycle by cycle from each scenario task.
module tb_regslv_req_arb;

  localparam int RN = 2;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk, rst_n;
  logic [RN-1:0]   m_req_vld, m_wr_en, m_rd_en, m_ack_vld, m_err;
  logic [RN*AW-1:0] m_addr;
  logic [RN*DW-1:0] m_wr_data;
  logic [DW-1:0]   m_rd_data, wr_data, rd_data;
  logic            req_vld, wr_en, rd_en, ack_vld, busy;
  logic [AW-1:0]   addr;
  logic [1:0]      state_dbg;
  int              total, bad;

  regslv_req_arb #(.REQ_NUM(RN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_vld(m_req_vld), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_addr(m_addr), .m_wr_data(m_wr_data),
    .m_ack_vld(m_ack_vld), .m_err(m_err), .m_rd_data(m_rd_data),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic wr, input logic rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req_vld[i]       = 1'b1;
    m_wr_en[i]         = wr;
    m_rd_en[i]         = rd;
    m_addr[i*AW +: AW] = a;
    m_wr_data[i*DW +: DW] = d;
  endtask

  task automatic drop(input int i);
    m_req_vld[i] = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL reset_req_vld: got %b want 0", req_vld); end
    total++; if (m_ack_vld !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", m_ack_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (addr !== 64'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", addr); end
    total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", m_rd_data); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    set_cmd(0, 1'b1, 1'b0, 64'h4, 32'h0001_C000);
    tick();
    total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL wr_req_vld: got %b want 1", req_vld); end
    total++; if ({wr_en, rd_en} !== 2'b10) begin bad++; $display("FAIL wr_cmd: got %b want 10", {wr_en, rd_en}); end
    total++; if (addr !== 64'h4) begin bad++; $display("FAIL wr_addr: got %h want 4", addr); end
    total++; if (wr_data !== 32'h0001_C000) begin bad++; $display("FAIL wr_data: got %h want 0001c000", wr_data); end
    total++; if (m_ack_vld !== 2'b00) begin bad++; $display("FAIL wr_early_ack: got %b want 00", m_ack_vld); end
    ack_vld = 1'b1; rd_data = 32'hDEAD_0001;
    tick();
    total++; if (m_ack_vld !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", m_ack_vld); end
    total++; if (m_err !== 2'b00) begin bad++; $display("FAIL wr_err: got %b want 00", m_err); end
    total++; if (m_rd_data !== 32'hDEAD_0001) begin bad++; $display("FAIL wr_rdata: got %h want dead0001", m_rd_data); end
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL wr_req_pulse: got %b want 0", req_vld); end
    total++; if (addr !== 64'h4) begin bad++; $display("FAIL wr_addr_hold: got %h want 4", addr); end
    ack_vld = 1'b0; drop(0);
    tick();
    total++; if (m_ack_vld !== 2'b00) begin bad++; $display("FAIL wr_ack_once: got %b want 00", m_ack_vld); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int exp_idx [4] = '{0, 1, 0, 1};
    logic [RN-1:0] exp_oh;
    logic [AW-1:0] exp_addr;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_cmd(0, 1'b0, 1'b1, 64'h10, 32'h0);
    set_cmd(1, 1'b0, 1'b1, 64'h20, 32'h0);
    for (int t = 0; t < 4; t++) begin
      exp_oh   = (exp_idx[t] == 0) ? 2'b01 : 2'b10;
      exp_addr = (exp_idx[t] == 0) ? 64'h10 : 64'h20;
      tick();
      total++; if (addr !== exp_addr) begin bad++; $display("FAIL rr_addr[%0d]: got %h want %h", t, addr, exp_addr); end
      total++; if (req_vld !== 1'b1) begin bad++; $display("FAIL rr_req_vld[%0d]: got %b want 1", t, req_vld); end
      ack_vld = 1'b1; rd_data = 32'h100 + t;
      tick();
      total++; if (m_ack_vld !== exp_oh) begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", t, m_ack_vld, exp_oh); end
      total++; if (m_rd_data !== 32'h100 + t) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", t, m_rd_data, 32'h100 + t); end
      ack_vld = 1'b0;
      if (t == 3) begin drop(0); drop(1); end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle[%0d]: got %b want 0", t, busy); end
    end
  endtask

  task automatic test_read_wait();
    set_cmd(0, 1'b0, 1'b1, 64'h8, 32'h0);
    tick();
    total++; if ({req_vld, wr_en, rd_en} !== 3'b101) begin bad++; $display("FAIL rw_issue: got %b want 101", {req_vld, wr_en, rd_en}); end
    for (int c = 2; c <= 6; c++) begin
      tick();
      total++; if ({busy, m_ack_vld, req_vld} !== 4'b1000) begin bad++; $display("FAIL rw_wait[%0d]: got %b want 1000", c, {busy, m_ack_vld, req_vld}); end
    end
    ack_vld = 1'b1; rd_data = 32'h0002_2000;
    tick();
    total++; if (m_ack_vld !== 2'b01) begin bad++; $display("FAIL rw_ack: got %b want 01", m_ack_vld); end
    total++; if (m_rd_data !== 32'h0002_2000) begin bad++; $display("FAIL rw_rdata: got %h want 00022000", m_rd_data); end
    total++; if ({busy, m_err} !== 3'b100) begin bad++; $display("FAIL rw_err_busy: got %b want 100", {busy, m_err}); end
    ack_vld = 1'b0; drop(0);
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rw_idle: got %b want 0", busy); end
  endtask

  task automatic test_timeout();
    set_cmd(1, 1'b1, 1'b0, 64'h30, 32'hCAFE);
    tick();
    total++; if ({req_vld, wr_en} !== 2'b11) begin bad++; $display("FAIL to_issue: got %b want 11", {req_vld, wr_en}); end
    for (int c = 2; c <= TO; c++) begin
      tick();
      total++; if ({busy, m_ack_vld} !== 3'b100) begin bad++; $display("FAIL to_wait[%0d]: got %b want 100", c, {busy, m_ack_vld}); end
    end
    tick();
    total++; if (m_ack_vld !== 2'b10) begin bad++; $display("FAIL to_ack: got %b want 10", m_ack_vld); end
    total++; if (m_err !== 2'b10) begin bad++; $display("FAIL to_err: got %b want 10", m_err); end
    total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", m_rd_data); end
    drop(1);
    tick();
    tick();
    tick();
    ack_vld = 1'b1; rd_data = 32'h0000_0BAD;
    set_cmd(0, 1'b0, 1'b1, 64'h40, 32'h0);
    tick();
    ack_vld = 1'b0;
    total++; if ({req_vld, m_ack_vld} !== 3'b100) begin bad++; $display("FAIL late_issue: got %b want 100", {req_vld, m_ack_vld}); end
    total++; if (addr !== 64'h40) begin bad++; $display("FAIL late_addr: got %h want 40", addr); end
    total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL late_rdata: got %h want 0", m_rd_data); end
    tick();
    total++; if ({busy, m_ack_vld} !== 3'b100) begin bad++; $display("FAIL late_ignored: got %b want 100", {busy, m_ack_vld}); end
    ack_vld = 1'b1; rd_data = 32'h1234;
    tick();
    total++; if ({m_ack_vld, m_err} !== 4'b0100) begin bad++; $display("FAIL late_next_ack: got %b want 0100", {m_ack_vld, m_err}); end
    total++; if (m_rd_data !== 32'h1234) begin bad++; $display("FAIL late_next_rdata: got %h want 1234", m_rd_data); end
    ack_vld = 1'b0; drop(0);
    tick();
  endtask

  task automatic test_illegal();
    set_cmd(0, 1'b1, 1'b1, 64'h44, 32'h0);
    tick();
    total++; if (req_vld !== 1'b0) begin bad++; $display("FAIL ill_both_req: got %b want 0", req_vld); end
    total++; if ({m_ack_vld, m_err} !== 4'b0101) begin bad++; $display("FAIL ill_both_ack: got %b want 0101", {m_ack_vld, m_err}); end
    total++; if (m_rd_data !== 32'h0) begin bad++; $display("FAIL ill_both_rdata: got %h want 0", m_rd_data); end
    drop(0);
    tick();
    total++; if ({busy, m_ack_vld} !== 3'b000) begin bad++; $display("FAIL ill_idle: got %b want 000", {busy, m_ack_vld}); end
    set_cmd(1, 1'b0, 1'b0, 64'h48, 32'h0);
    tick();
    total++; if ({req_vld, m_ack_vld, m_err} !== 5'b01010) begin bad++; $display("FAIL ill_none: got %b want 01010", {req_vld, m_ack_vld, m_err}); end
    drop(1);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_cmd(0, 1'b0, 1'b1, 64'h60, 32'h0);
    tick();
    total++; if ({req_vld, addr} !== {1'b1, 64'h60}) begin bad++; $display("FAIL rst_pre_issue: got %b/%h want 1/60", req_vld, addr); end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++; if ({busy, rd_en, state_dbg} !== 4'b0000) begin bad++; $display("FAIL rst_async_ctl: got %b want 0000", {busy, rd_en, state_dbg}); end
    total++; if (addr !== 64'h0) begin bad++; $display("FAIL rst_async_addr: got %h want 0", addr); end
    total++; if ({req_vld, m_ack_vld} !== 3'b000) begin bad++; $display("FAIL rst_async_pulses: got %b want 000", {req_vld, m_ack_vld}); end
    set_cmd(1, 1'b0, 1'b1, 64'h70, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (addr !== 64'h60) begin bad++; $display("FAIL rst_ptr_m0_first: got %h want 60", addr); end
    ack_vld = 1'b1; rd_data = 32'h600D;
    tick();
    total++; if ({m_ack_vld, m_rd_data} !== {2'b01, 32'h600D}) begin bad++; $display("FAIL rst_reissue_ack: got %b/%h want 01/600d", m_ack_vld, m_rd_data); end
    ack_vld = 1'b0; drop(0); drop(1);
    tick();
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; ack_vld = 1'b0; rd_data = '0;
    m_req_vld = '0; m_wr_en = '0; m_rd_en = '0; m_addr = '0; m_wr_data = '0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read_wait();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regslv_req_arb.md
# regslv_req_arb

Round-robin access arbiter that shares one register-slave access port (req_vld/ack_vld/wr_en/rd_en/addr/wr_data/rd_data) among REQ_NUM independent masters. It sits between the masters (CPU bridge, debug port, DMA config engine) and a generated `regslv_*` block. It allows one transaction in flight at a time, bounds every transaction with a timeout, and rejects malformed commands locally.

## Interface
- REQ_NUM, 2: number of masters (2..8)
- ADDR_WIDTH, 64: address width
- DATA_WIDTH, 32: data width
- TIMEOUT, 255: max cycles in WAIT before error response (≥2)

Ports:
- clk  in  1  single clock; all logic in this domain
- rst_n  in  1  asynchronous, active-low reset
- m_req_vld  in  REQ_NUM  per-master request level
- m_wr_en / m_rd_en  in  REQ_NUM  per-master command type
- m_addr  in  REQ_NUM*ADDR_WIDTH  packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wr_data  in  REQ_NUM*DATA_WIDTH  packed, same scheme
- m_ack_vld  out  REQ_NUM  one-cycle completion pulse to the granted master
- m_err  out  REQ_NUM  valid with m_ack_vld; 1 = timeout or illegal command
- m_rd_data  out  DATA_WIDTH  shared read data, valid with any m_ack_vld
- req_vld  out  1  slave request pulse
- wr_en / rd_en / addr / wr_data  out  slave command, registered
- ack_vld  in  1  slave completion
- rd_data  in  DATA_WIDTH  slave read data, valid with ack_vld
- busy  out  1  state != IDLE

## Operation
- Master rules: assert m_req_vld with a stable command. Hold it until m_ack_vld is sampled. Deassert at that same clock edge.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no request: stay in IDLE; all pulses are 0.
- IDLE, any request:
  - Round-robin pick: search starts at ptr+1 mod REQ_NUM.
  - Register grant index, wr_en, rd_en, addr and wr_data; set ptr = grant.
  - Legal command (exactly one of wr_en/rd_en set): assert req_vld for one cycle, reset counter, go to WAIT.
  - Illegal command (both or neither set): no slave access; go to RESP with err=1, m_rd_data=0.
- WAIT:
  - ack_vld=1: capture rd_data (writes capture whatever the slave returns), err=0, go to RESP.
  - ack_vld=0 and count == TIMEOUT-1: err=1, m_rd_data=0, go to RESP.
  - Otherwise: count++.
- RESP: m_ack_vld[grant]=1 and m_err[grant]=err for exactly one cycle, then IDLE.
- Slave command outputs hold their value from issue until the next grant.
- ack_vld outside WAIT (a late ack after a timeout) is ignored and does not corrupt the next transaction.
- Counter width: $clog2(TIMEOUT+1). It never wraps.
- ptr resets to REQ_NUM-1, so master 0 has first priority.
- Reset values: state=IDLE, all outputs 0, counter 0, grant 0.
- Reset mid-transaction: the transaction is aborted with no ack to the master; the master must re-issue.

## Timing
- Cycle 0: IDLE samples the request.
- Cycle 1: req_vld=1 and the command is on the slave port (first WAIT cycle).
- Slave ack in cycle k ≥ 1: m_ack_vld in cycle k+1. Minimum latency is 2 cycles (zero-wait regfile write).
- Timeout: m_ack_vld+m_err in cycle TIMEOUT+1.
- Illegal command: m_ack_vld+m_err in cycle 1.
- Back-to-back: a new grant is sampled the cycle after RESP. Throughput is one transaction per 3 cycles at best.
- A master requesting continuously waits at most REQ_NUM-1 other transactions.

## Structure
- Package `regslv_arb_pkg`: state enum `arb_state_e` {IDLE, WAIT, RESP}; localparams for the err encoding.
- Sub-module `rr_arbiter`: purely combinational. Inputs: request vector, ptr. Outputs: one-hot grant and encoded index.
- The top holds the FSM, command registers, counter and response mux.

## Test plan
- Single write: m0 writes addr 0x4, data 0x0001_C000; slave acks in cycle 1 -> req_vld pulse in cycle 1, m_ack_vld[0] in cycle 2, m_err=0.
- Contention: m0 and m1 request together from reset -> m0 served first, then m1. With both held continuously, grants alternate 0,1,0,1.
- Read with wait states: slave acks 5 cycles after req_vld with rd_data 0x0002_2000 -> m_rd_data=0x0002_2000 exactly with m_ack_vld, and busy is high throughout.
- Timeout: TIMEOUT=8, slave never acks -> m_ack_vld+m_err in cycle 9. A late ack in cycle 12 is ignored, and the next transaction completes normally.
- Illegal command: wr_en=rd_en=1 -> req_vld stays 0; m_ack_vld+m_err in cycle 1 with m_rd_data=0.
- Reset mid-WAIT: assert rst_n=0 in cycle 3 -> all outputs 0 asynchronously, state IDLE, ptr restored so m0 is granted first.
